// File: rtl/uart_tx_if.sv
// Host-side interface of the UART transmitter: write strobe, byte, serial line and status.
// dbg_state mirrors the transmitter FSM so checkers can bind to it.
interface uart_tx_if;
  logic       write;
  logic [7:0] data;
  logic       tx;
  logic       txrdy;
  logic       txempty;
  logic [2:0] dbg_state;

  // Handshake: a byte is taken on any rising edge where write=1 and txrdy=1.
  // With txrdy=0 the strobe is dropped, not queued.
  modport master (
    output write,
    output data,
    input  tx,
    input  txrdy,
    input  txempty,
    input  dbg_state
  );

  modport slave (
    input  write,
    input  data,
    output tx,
    output txrdy,
    output txempty,
    output dbg_state
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter on the 16x baud clock: holding register (THR), shift register (TSR), framing FSM.
// Build option UART_TX_PARITY_EN adds an odd parity bit between data[7] and the stop bit.
module uart_tx (
  input  logic      mclkx16,
  input  logic      reset,
  uart_tx_if.slave  bus
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd4
  } state_t;
`endif

  state_t     state_q, state_d;
  logic [3:0] prescaler_q;
  logic       tick;
  logic [7:0] thr_q;
  logic       thr_full_q, thr_full_d;
  logic [7:0] tsr_q, tsr_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       tx_q, tx_d;
  logic       load_tsr;
  logic       accept;
`ifdef UART_TX_PARITY_EN
  logic       par_q, par_d;
`endif

  assign tick   = (prescaler_q == 4'd15);
  assign accept = bus.write && !thr_full_q;

  // Next-state and datapath; everything but THR acceptance waits for a tick.
  always_comb begin
    state_d   = state_q;
    tsr_d     = tsr_q;
    bit_idx_d = bit_idx_q;
    tx_d      = tx_q;
    load_tsr  = 1'b0;
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (thr_full_q) begin
            state_d  = START;
            load_tsr = 1'b1;
            tx_d     = 1'b0;
          end
        end
        START: begin
          state_d   = DATA;
          tx_d      = tsr_q[0];
          tsr_d     = {1'b0, tsr_q[7:1]};
          bit_idx_d = 3'd0;
        end
        DATA: begin
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = par_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            tx_d      = tsr_q[0];
            tsr_d     = {1'b0, tsr_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
`endif
        STOP: begin
          // A byte already waiting starts immediately, with no idle bit.
          if (thr_full_q) begin
            state_d  = START;
            load_tsr = 1'b1;
            tx_d     = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end
    if (load_tsr) begin
      tsr_d = thr_q;
    end
  end

  // THR is full while a byte waits; a transfer and an accept never share an edge.
  always_comb begin
    thr_full_d = thr_full_q;
    if (load_tsr) begin
      thr_full_d = 1'b0;
    end else if (accept) begin
      thr_full_d = 1'b1;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_comb begin
    par_d = par_q;
    if (load_tsr) begin
      par_d = ~^thr_q;
    end
  end
`endif

  always_ff @(posedge mclkx16) begin
    if (reset) begin
      state_q     <= IDLE;
      prescaler_q <= 4'd0;
      thr_q       <= 8'd0;
      thr_full_q  <= 1'b0;
      tsr_q       <= 8'd0;
      bit_idx_q   <= 3'd0;
      tx_q        <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      prescaler_q <= prescaler_q + 4'd1;
      thr_full_q  <= thr_full_d;
      tsr_q       <= tsr_d;
      bit_idx_q   <= bit_idx_d;
      tx_q        <= tx_d;
      if (accept) begin
        thr_q <= bus.data;
      end
`ifdef UART_TX_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  assign bus.tx        = tx_q;
  assign bus.txrdy     = !thr_full_q;
  assign bus.txempty   = (state_q == IDLE) && !thr_full_q;
  assign bus.dbg_state = state_q;

endmodule
